ortak_yol_hakemi: RTL and testbench
===================================

# ortak_yol_hakemi

Common-data-bus (CDB) arbiter for the Tomasulo executor: the adder and multiplier result paths each push a completed `{etiket, deger}` result into the arbiter, and it broadcasts at most one result per cycle on a single registered bus. Reservation stations and the register alias table snoop that bus to capture operands and retire destinations. Each source gets a small result buffer, and a round-robin policy prevents either unit from starving the other.

## Interface
- `ETIKET_W`, default 4: tag width. Tags 0–7 are adder rows; tags 8–15 are multiplier rows.
- `VERI_W`, default 32: result width.
- `DERINLIK`, default 2: per-source buffer depth. Must be a power of two, at least 2.
- `saat`, in, 1: clock. All state updates on the rising edge.
- `sifirla_n`, in, 1: reset. Synchronous, active-low.
- `top_gecerli`, in, 1: adder result valid.
- `top_hazir`, out, 1: adder buffer can accept a result.
- `top_etiket`, in, `ETIKET_W`: adder result tag.
- `top_deger`, in, `VERI_W`: adder result value.
- `carp_gecerli`, `carp_hazir`, `carp_etiket`, `carp_deger`: the same four signals for the multiplier.
- `yol_gecerli`, out, 1: CDB broadcast valid.
- `yol_etiket`, out, `ETIKET_W`: broadcast tag.
- `yol_deger`, out, `VERI_W`: broadcast value.
- `yol_kaynak`, out, 1: broadcast source, 0 = adder, 1 = multiplier.
- `bos`, out, 1: both buffers empty and no broadcast this cycle.

## Operation
- **Accept.** A result is accepted on an edge where `x_gecerli & x_hazir`. Accepted results are written to that source's FIFO. When `x_hazir` = 0, `x_gecerli` is ignored and the result is not stored; the producer must hold it.
- **`x_hazir`.** Equals `!full`, computed from the registered occupancy only. A pop in the same cycle does not make room.
- **Arbitration.** Evaluated every cycle on the FIFO heads.
  - If only one FIFO is non-empty, that FIFO wins.
  - If both are non-empty, the winner is the source opposite to `son_kazanan`.
  - The winner's head is popped. `son_kazanan` updates only when a grant occurs.
- **Round-robin state machine.** States ONCELIK_TOP (reset state) and ONCELIK_CARP.
  - A grant to the adder moves to ONCELIK_CARP.
  - A grant to the multiplier moves to ONCELIK_TOP.
  - Under continuous contention the two sources strictly alternate.
- **Output register.**
  - `yol_*` loads the popped entry.
  - `yol_gecerli` is 1 for exactly one cycle per result; each accepted result is broadcast exactly once.
  - When there is no grant, `yol_gecerli` = 0 and `yol_etiket`/`yol_deger` hold their last values.
- **Tags.** Passed through unchecked. Ordering is FIFO within a source; there is no ordering guarantee across sources.
- **`bos`.** Equals `!yol_gecerli & top_empty & carp_empty`. The executor ANDs it into its completion flag.

## Timing
- **Reset values** (edge with `sifirla_n` = 0): `yol_gecerli` = 0, `yol_etiket` = 0, `yol_deger` = 0, `yol_kaynak` = 0, `son_kazanan` = adder (state ONCELIK_TOP), FIFOs empty, `bos` = 1. While `sifirla_n` = 0, both `x_hazir` are forced to 0.
- **Reset mid-operation.** All buffered results are dropped. No broadcast occurs on the cycle after the reset edge. A push presented on the reset edge is discarded.
- **Latency.** A result accepted at edge N into an empty, uncontended FIFO appears with `yol_gecerli` = 1 after edge N+1, i.e. one cycle.
- **Throughput.** One broadcast per cycle total. Each source sustains one result per cycle only while the other source is idle.
- **Simultaneous push and pop on one FIFO.** Allowed when not full; occupancy is unchanged.
- **Pointers.** Read/write pointers carry one extra wrap bit. Full means indices are equal and wrap bits differ; empty means the pointers are equal. Wrap-around is exercised every `DERINLIK` pushes.
- **Worst-case wait.** A head entry is granted within 2 cycles of reaching the head.

## Structure
- Package `ovy_pkg` holds:
  - `ETIKET_W` and `VERI_W` defaults;
  - a typedef `sonuc_t` = `{etiket, deger}`;
  - source enum constants `KAYNAK_TOP` = 0 and `KAYNAK_CARP` = 1;
  - round-robin state constants ONCELIK_TOP and ONCELIK_CARP;
  - tag-space constant `CARP_ETIKET_TABANI` = 8.
- Sub-module `sonuc_fifo` (parameters `DERINLIK` and data width; ports `push`, `pop`, `din`, `dout`, `full`, `empty`) is instantiated twice. Arbitration and the output register live in the top level.

## Test plan
- **Reset.** Reset, then idle 3 cycles → `yol_gecerli` = 0, `bos` = 1, both `x_hazir` = 1. Assert `sifirla_n` = 0 → both `x_hazir` = 0.
- **Single add.** Push adder `{3, 0x0000_0005}` at edge N → `yol_gecerli` = 1, `yol_etiket` = 3, `yol_deger` = 5, `yol_kaynak` = 0 in the cycle after edge N+1. `bos` = 1 the cycle after.
- **Contention from reset.** Push adder tag 1 and multiplier tag 9 on the same edge → broadcast order is tag 1, then tag 9, in consecutive cycles.
- **Continuous contention.** Both sources push every cycle for 8 cycles → grants alternate A, M, A, M, …. `x_hazir` drops to 0 on the losing side once `DERINLIK` entries back up. No result is lost or duplicated; a scoreboard verifies all 16 tags.
- **Full and wrap.** Hold the multiplier's push while blocking grants with a backlog of adder results. Fill `DERINLIK` = 2 → `carp_hazir` = 0 and the extra `carp_gecerli` is ignored. Drain and refill 3 times → FIFO order is preserved across wrap.
- **Reset mid-operation.** With 2 entries buffered, assert `sifirla_n` = 0 for one edge → no broadcast afterward and `bos` = 1. A fresh push of tag 4 then broadcasts normally.

Source files
------------

// File: rtl/ortak_yol_hakemi_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
package ovy_pkg;

  localparam int VARSAYILAN_ETIKET_W = 4;
  localparam int VARSAYILAN_VERI_W   = 32;
  localparam int CARP_ETIKET_TABANI  = 8;

  typedef struct packed {
    logic [VARSAYILAN_ETIKET_W-1:0] etiket;
    logic [VARSAYILAN_VERI_W-1:0]   deger;
  } sonuc_t;

  typedef enum logic {
    KAYNAK_TOP  = 1'b0,
    KAYNAK_CARP = 1'b1
  } kaynak_e;

  typedef enum logic {
    ONCELIK_TOP  = 1'b0,
    ONCELIK_CARP = 1'b1
  } oncelik_e;

endpackage

// File: rtl/ortak_yol_hakemi_if.sv
// Producer-side handshakes and the broadcast bus of the CDB arbiter.
interface ortak_yol_hakemi_if #(
  parameter int ETIKET_W = ovy_pkg::VARSAYILAN_ETIKET_W,
  parameter int VERI_W   = ovy_pkg::VARSAYILAN_VERI_W
);
  logic                top_gecerli;
  logic                top_hazir;
  logic [ETIKET_W-1:0] top_etiket;
  logic [VERI_W-1:0]   top_deger;
  logic                carp_gecerli;
  logic                carp_hazir;
  logic [ETIKET_W-1:0] carp_etiket;
  logic [VERI_W-1:0]   carp_deger;
  logic                yol_gecerli;
  logic [ETIKET_W-1:0] yol_etiket;
  logic [VERI_W-1:0]   yol_deger;
  logic                yol_kaynak;
  logic                bos;

  modport slave (
    input  top_gecerli, top_etiket, top_deger,
    input  carp_gecerli, carp_etiket, carp_deger,
    output top_hazir, carp_hazir,
    output yol_gecerli, yol_etiket, yol_deger, yol_kaynak, bos
  );

  modport master (
    output top_gecerli, top_etiket, top_deger,
    output carp_gecerli, carp_etiket, carp_deger,
    input  top_hazir, carp_hazir,
    input  yol_gecerli, yol_etiket, yol_deger, yol_kaynak, bos
  );
endinterface

// File: rtl/ortak_yol_hakemi_sonuc_fifo.sv
// Per-source result buffer; pointers carry an extra wrap bit to tell full from empty.
module sonuc_fifo #(
  parameter int DERINLIK = 2,
  parameter int GENISLIK = 36
) (
  input  logic                saat,
  input  logic                sifirla_n,
  input  logic                push,
  input  logic                pop,
  input  logic [GENISLIK-1:0] din,
  output logic [GENISLIK-1:0] dout,
  output logic                full,
  output logic                empty
);
  localparam int AW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
  localparam logic [AW:0] BIR = 1;

  logic [AW:0]         yaz;
  logic [AW:0]         oku;
  logic [GENISLIK-1:0] bellek [DERINLIK];

  assign empty = (yaz == oku);
  assign full  = (yaz[AW] != oku[AW]) && (yaz[AW-1:0] == oku[AW-1:0]);
  assign dout  = bellek[oku[AW-1:0]];

  always_ff @(posedge saat) begin
    if (!sifirla_n) begin
      yaz <= '0;
      oku <= '0;
    end else begin
      if (push && !full) yaz <= yaz + BIR;
      if (pop && !empty) oku <= oku + BIR;
    end
  end

  always_ff @(posedge saat) begin
    if (push && !full) bellek[yaz[AW-1:0]] <= din;
  end
endmodule

// File: rtl/ortak_yol_hakemi.sv
// CDB arbiter: two result FIFOs, round-robin grant, one registered broadcast per cycle.
//   state        | meaning
//   ONCELIK_TOP  | adder wins if both heads are waiting
//   ONCELIK_CARP | multiplier wins if both heads are waiting
module ortak_yol_hakemi #(
  parameter int ETIKET_W = ovy_pkg::VARSAYILAN_ETIKET_W,
  parameter int VERI_W   = ovy_pkg::VARSAYILAN_VERI_W,
  parameter int DERINLIK = 2
) (
  input  logic saat,
  input  logic sifirla_n,
  ortak_yol_hakemi_if.slave bag
);
  import ovy_pkg::*;

  localparam int SW = ETIKET_W + VERI_W;

  logic [SW-1:0]       top_dout, carp_dout;
  logic                top_full, top_empty, carp_full, carp_empty;
  logic                top_push, carp_push;
  logic                top_izin, carp_izin;
  oncelik_e            durum, durum_sonraki;
  logic                yol_gecerli_r;
  logic [ETIKET_W-1:0] yol_etiket_r;
  logic [VERI_W-1:0]   yol_deger_r;
  logic                yol_kaynak_r;

  // Readiness looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign bag.top_hazir  = sifirla_n & ~top_full;
  assign bag.carp_hazir = sifirla_n & ~carp_full;
  assign top_push  = bag.top_gecerli  & bag.top_hazir;
  assign carp_push = bag.carp_gecerli & bag.carp_hazir;

  sonuc_fifo #(.DERINLIK(DERINLIK), .GENISLIK(SW)) u_top_fifo (
    .saat(saat), .sifirla_n(sifirla_n),
    .push(top_push), .pop(top_izin),
    .din({bag.top_etiket, bag.top_deger}), .dout(top_dout),
    .full(top_full), .empty(top_empty)
  );

  sonuc_fifo #(.DERINLIK(DERINLIK), .GENISLIK(SW)) u_carp_fifo (
    .saat(saat), .sifirla_n(sifirla_n),
    .push(carp_push), .pop(carp_izin),
    .din({bag.carp_etiket, bag.carp_deger}), .dout(carp_dout),
    .full(carp_full), .empty(carp_empty)
  );

  always_ff @(posedge saat) begin
    if (!sifirla_n) durum <= ONCELIK_TOP;
    else            durum <= durum_sonraki;
  end

  always_comb begin
    durum_sonraki = durum;
    top_izin      = 1'b0;
    carp_izin     = 1'b0;
    case (durum)
      ONCELIK_TOP: begin
        if (!top_empty) begin
          top_izin      = 1'b1;
          durum_sonraki = ONCELIK_CARP;
        end else if (!carp_empty) begin
          carp_izin = 1'b1;
        end
      end
      ONCELIK_CARP: begin
        if (!carp_empty) begin
          carp_izin     = 1'b1;
          durum_sonraki = ONCELIK_TOP;
        end else if (!top_empty) begin
          top_izin = 1'b1;
        end
      end
      default: durum_sonraki = ONCELIK_TOP;
    endcase
  end

  always_ff @(posedge saat) begin
    if (!sifirla_n) begin
      yol_gecerli_r <= 1'b0;
      yol_etiket_r  <= '0;
      yol_deger_r   <= '0;
      yol_kaynak_r  <= KAYNAK_TOP;
    end else begin
      yol_gecerli_r <= top_izin | carp_izin;
      if (top_izin) begin
        {yol_etiket_r, yol_deger_r} <= top_dout;
        yol_kaynak_r                <= KAYNAK_TOP;
      end else if (carp_izin) begin
        {yol_etiket_r, yol_deger_r} <= carp_dout;
        yol_kaynak_r                <= KAYNAK_CARP;
      end
    end
  end

  assign bag.yol_gecerli = yol_gecerli_r;
  assign bag.yol_etiket  = yol_etiket_r;
  assign bag.yol_deger   = yol_deger_r;
  assign bag.yol_kaynak  = yol_kaynak_r;
  assign bag.bos         = ~yol_gecerli_r & top_empty & carp_empty;
endmodule

// File: tb/tb_ortak_yol_hakemi.sv
// Self-checking bench: queue-level reference model compared every cycle, plus directed literal checks.
module tb_ortak_yol_hakemi;
  import ovy_pkg::*;

  localparam int EW = 4;
  localparam int VW = 32;
  localparam int D  = 2;

  logic saat = 1'b0;
  logic sifirla_n = 1'b0;
  always #5 saat = ~saat;

  ortak_yol_hakemi_if #(.ETIKET_W(EW), .VERI_W(VW)) bag ();

  ortak_yol_hakemi #(.ETIKET_W(EW), .VERI_W(VW), .DERINLIK(D)) dut (
    .saat(saat),
    .sifirla_n(sifirla_n),
    .bag(bag)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
    checks++;
    if (gercek !== beklenen) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", ad, gercek, beklenen, $time);
    end
  endtask

  function automatic logic [VW-1:0] deger_of(input int t);
    return 32'hC0DE_0000 + 32'(t) * 32'h0000_0111;
  endfunction

  // Reference model: two bounded queues, a "who is preferred next" bit, and the bus register.
  typedef struct packed {
    logic [EW-1:0] e;
    logic [VW-1:0] d;
  } kayit_t;

  kayit_t        m_top[$];
  kayit_t        m_carp[$];
  bit            m_sira_carp;
  logic          m_gec;
  logic [EW-1:0] m_et;
  logic [VW-1:0] m_dg;
  logic          m_kay;
  bit            model_hazir = 0;

  always @(posedge saat) begin
    kayit_t k;
    bit at, ac;
    if (!sifirla_n) begin
      m_top.delete();
      m_carp.delete();
      m_gec = 0; m_et = '0; m_dg = '0; m_kay = 0;
      m_sira_carp = 0;
      model_hazir = 1;
    end else begin
      at = (bag.top_gecerli === 1'b1) && (m_top.size() < D);
      ac = (bag.carp_gecerli === 1'b1) && (m_carp.size() < D);
      m_gec = 0;
      if (m_top.size() > 0 && (m_carp.size() == 0 || !m_sira_carp)) begin
        k = m_top.pop_front();
        m_gec = 1; m_et = k.e; m_dg = k.d; m_kay = 0;
        m_sira_carp = 1;
      end else if (m_carp.size() > 0) begin
        k = m_carp.pop_front();
        m_gec = 1; m_et = k.e; m_dg = k.d; m_kay = 1;
        m_sira_carp = 0;
      end
      if (at) m_top.push_back('{e: bag.top_etiket, d: bag.top_deger});
      if (ac) m_carp.push_back('{e: bag.carp_etiket, d: bag.carp_deger});
    end
  end

  logic [EW-1:0] log_et[$];
  logic          log_kay[$];
  bit            top_tikali, carp_tikali;

  always @(negedge saat) begin
    if (model_hazir) begin
      chk("yol_gecerli", bag.yol_gecerli, m_gec);
      chk("yol_etiket", bag.yol_etiket, m_et);
      chk("yol_deger", bag.yol_deger, m_dg);
      chk("yol_kaynak", bag.yol_kaynak, m_kay);
      chk("bos", bag.bos, (!m_gec && m_top.size() == 0 && m_carp.size() == 0));
      chk("top_hazir", bag.top_hazir, (sifirla_n && m_top.size() < D));
      chk("carp_hazir", bag.carp_hazir, (sifirla_n && m_carp.size() < D));
    end
    if (bag.yol_gecerli === 1'b1) begin
      log_et.push_back(bag.yol_etiket);
      log_kay.push_back(bag.yol_kaynak);
    end
    if (sifirla_n && bag.top_gecerli === 1'b1 && bag.top_hazir === 1'b0) top_tikali = 1;
    if (sifirla_n && bag.carp_gecerli === 1'b1 && bag.carp_hazir === 1'b0) carp_tikali = 1;
  end

  task automatic adim();
    @(posedge saat);
    #1;
  endtask

  task automatic kayit_temizle();
    log_et.delete();
    log_kay.delete();
    top_tikali = 0;
    carp_tikali = 0;
  endtask

  // Each producer holds its current result until it is accepted.
  task automatic push_akis(input int na, input int a0, input int nm, input int m0, input int limit);
    int ia, im, n;
    bit acc_a, acc_m;
    ia = 0; im = 0; n = 0;
    while ((ia < na || im < nm) && n < limit) begin
      bag.top_gecerli  = (ia < na);
      bag.top_etiket   = EW'(a0 + ia);
      bag.top_deger    = deger_of(a0 + ia);
      bag.carp_gecerli = (im < nm);
      bag.carp_etiket  = EW'(m0 + im);
      bag.carp_deger   = deger_of(m0 + im);
      @(negedge saat);
      acc_a = bag.top_gecerli && (bag.top_hazir === 1'b1);
      acc_m = bag.carp_gecerli && (bag.carp_hazir === 1'b1);
      adim();
      if (acc_a) ia++;
      if (acc_m) im++;
      n++;
    end
    if (ia < na || im < nm) begin
      checks++;
      failures++;
      $display("FAIL push_akis_timeout: accepted top=%0d carp=%0d required top=%0d carp=%0d", ia, im, na, nm);
    end
    bag.top_gecerli  = 1'b0;
    bag.carp_gecerli = 1'b0;
  endtask

  task automatic bosa_kadar(input int limit);
    int n;
    bit tamam;
    n = 0; tamam = 0;
    while (!tamam && n < limit) begin
      @(negedge saat);
      if (bag.bos === 1'b1) tamam = 1;
      n++;
    end
    if (!tamam) begin
      checks++;
      failures++;
      $display("FAIL bos_timeout: bos=%0b after %0d cycles, required 1", bag.bos, limit);
    end
    adim();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded, required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [EW-1:0] beklenen_et;
    int ci, ai;
    bag.top_gecerli = 0; bag.top_etiket = '0; bag.top_deger = '0;
    bag.carp_gecerli = 0; bag.carp_etiket = '0; bag.carp_deger = '0;
    sifirla_n = 0;

    // Reset
    adim();
    @(negedge saat);
    chk("rst_top_hazir", bag.top_hazir, 0);
    chk("rst_carp_hazir", bag.carp_hazir, 0);
    adim();
    sifirla_n = 1;
    repeat (3) adim();
    @(negedge saat);
    chk("idle_yol_gecerli", bag.yol_gecerli, 0);
    chk("idle_bos", bag.bos, 1);
    chk("idle_top_hazir", bag.top_hazir, 1);
    chk("idle_carp_hazir", bag.carp_hazir, 1);
    chk("idle_yol_etiket", bag.yol_etiket, 0);
    chk("idle_yol_deger", bag.yol_deger, 0);
    adim();

    // Single add: accepted at edge N, on the bus after edge N+1
    bag.top_gecerli = 1; bag.top_etiket = 4'd3; bag.top_deger = 32'h0000_0005;
    adim();
    bag.top_gecerli = 0;
    adim();
    @(negedge saat);
    chk("tek_gecerli", bag.yol_gecerli, 1);
    chk("tek_etiket", bag.yol_etiket, 3);
    chk("tek_deger", bag.yol_deger, 32'h5);
    chk("tek_kaynak", bag.yol_kaynak, 0);
    adim();
    @(negedge saat);
    chk("tek_sonra_bos", bag.bos, 1);
    chk("tek_sonra_gecerli", bag.yol_gecerli, 0);
    adim();

    // Contention straight out of reset: adder first
    sifirla_n = 0;
    adim();
    sifirla_n = 1;
    bag.top_gecerli = 1; bag.top_etiket = 4'd1; bag.top_deger = deger_of(1);
    bag.carp_gecerli = 1; bag.carp_etiket = 4'd9; bag.carp_deger = deger_of(9);
    adim();
    bag.top_gecerli = 0; bag.carp_gecerli = 0;
    adim();
    @(negedge saat);
    chk("cek1_gecerli", bag.yol_gecerli, 1);
    chk("cek1_etiket", bag.yol_etiket, 1);
    chk("cek1_kaynak", bag.yol_kaynak, 0);
    adim();
    @(negedge saat);
    chk("cek2_gecerli", bag.yol_gecerli, 1);
    chk("cek2_etiket", bag.yol_etiket, 9);
    chk("cek2_kaynak", bag.yol_kaynak, 1);
    adim();
    bosa_kadar(10);

    // Continuous contention: strict alternation 0,8,1,9,...,7,15
    kayit_temizle();
    push_akis(8, 0, 8, CARP_ETIKET_TABANI, 60);
    bosa_kadar(40);
    chk("surekli_adet", log_et.size(), 16);
    for (int i = 0; i < 16; i++) begin
      beklenen_et = (i % 2 == 0) ? EW'(i / 2) : EW'(CARP_ETIKET_TABANI + i / 2);
      chk($sformatf("surekli_sira_%0d", i), (i < log_et.size()) ? log_et[i] : 'x, beklenen_et);
    end
    chk("surekli_top_tikali", top_tikali, 1);
    chk("surekli_carp_tikali", carp_tikali, 1);

    // Fill, drain and refill three times; FIFO order must survive pointer wrap
    kayit_temizle();
    for (int r = 0; r < 3; r++) begin
      push_akis(4, 0, 4, CARP_ETIKET_TABANI + r, 40);
      bosa_kadar(30);
    end
    chk("sarma_adet", log_et.size(), 24);
    ci = 0; ai = 0;
    for (int i = 0; i < log_et.size(); i++) begin
      if (log_kay[i] === 1'b1) begin
        beklenen_et = EW'(CARP_ETIKET_TABANI + (ci / 4) + (ci % 4));
        chk($sformatf("sarma_carp_%0d", ci), log_et[i], beklenen_et);
        ci++;
      end else begin
        beklenen_et = EW'(ai % 4);
        chk($sformatf("sarma_top_%0d", ai), log_et[i], beklenen_et);
        ai++;
      end
    end
    chk("sarma_carp_adet", ci, 12);
    chk("sarma_carp_dolu", carp_tikali, 1);

    // Reset with results buffered; a push on the reset edge is dropped too
    bag.top_gecerli = 1; bag.top_etiket = 4'd2; bag.top_deger = deger_of(2);
    bag.carp_gecerli = 1; bag.carp_etiket = 4'd10; bag.carp_deger = deger_of(10);
    adim();
    bag.top_etiket = 4'd3; bag.top_deger = deger_of(3);
    bag.carp_etiket = 4'd11; bag.carp_deger = deger_of(11);
    adim();
    bag.top_etiket = 4'd7; bag.top_deger = deger_of(7);
    bag.carp_gecerli = 0;
    sifirla_n = 0;
    @(negedge saat);
    chk("ortarst_top_hazir", bag.top_hazir, 0);
    chk("ortarst_carp_hazir", bag.carp_hazir, 0);
    adim();
    sifirla_n = 1;
    bag.top_gecerli = 0;
    kayit_temizle();
    @(negedge saat);
    chk("ortarst_gecerli", bag.yol_gecerli, 0);
    chk("ortarst_bos", bag.bos, 1);
    repeat (3) adim();
    chk("ortarst_yayin_yok", log_et.size(), 0);
    bag.top_gecerli = 1; bag.top_etiket = 4'd4; bag.top_deger = deger_of(4);
    adim();
    bag.top_gecerli = 0;
    adim();
    @(negedge saat);
    chk("ortarst_yeni_gecerli", bag.yol_gecerli, 1);
    chk("ortarst_yeni_etiket", bag.yol_etiket, 4);
    chk("ortarst_yeni_deger", bag.yol_deger, deger_of(4));
    adim();
    bosa_kadar(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
